mac_dot: RTL
============

Name: mac_dot

Overview:
- Streaming multi-lane signed dot-product accumulator.
- Each accepted beat multiplies LANES value/weight pairs, sums the products, and accumulates them into a bias-seeded accumulator.
- On the beat flagged last, the block emits one saturated result per vector.
- Sits between the activation/weight fetch logic and the activation stage of the network layers.

Parameters:
- N, 8: signed width of each value and weight element.
- LANES, 4: element pairs per beat; must be >= 1.
- ACC_W, 24: signed accumulator width; must be >= 2*N+$clog2(LANES).
- OUT_W, 16: signed result width; must be <= ACC_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- value_i  in  LANES*N  packed signed values; lane k = [k*N +: N].
- weight_i  in  LANES*N  packed signed weights; same lane packing.
- bias_i  in  ACC_W  signed accumulator seed; sampled only on the first beat of a vector.
- last_i  in  1  marks the final beat of a vector.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumer ready.
- out_data_o  out  OUT_W  signed saturated dot-product result.
- out_sat_o  out  1  result was clamped.

Behaviour:
- Reset (async assert, sync deassert): out_valid_o=0, out_data_o=0, out_sat_o=0, first-beat flag=1, all pipeline valid bits=0, accumulator=0.
  - in_ready_o=1 immediately after reset.
  - Reset mid-vector discards all partial state; the next accepted beat is treated as a first beat.
- Stall: stall = out_valid_o && !out_ready_i.
  - in_ready_o = !stall (combinational).
  - While stall is high the whole pipeline freezes: no register other than the output holds changes.
- Pipeline, two stages.
  - S1 registers LANES full-width 2N signed products, plus the beat's last and first flags and a valid bit.
  - S2 sums the products (signed, width 2N+$clog2(LANES)), sign-extends the sum to ACC_W, and updates the accumulator:
    - first beat: acc <= bias + sum
    - otherwise: acc <= acc + sum
  - Bias is carried through S1 alongside the first flag.
- First-beat flag: set by reset and by acceptance of a last beat; cleared by acceptance of a non-last beat.
- Result output: when S2 processes a valid last beat, the output register loads clamp(acc_next) and out_sat_o loads the clamp flag, with out_valid_o=1.
  - The accumulator then restarts from the next vector's bias.
  - Latency: last beat accepted in cycle t gives out_valid_o=1 in cycle t+2 (no stall).
  - Throughput is one beat per cycle. Back-to-back vectors, including consecutive single-beat vectors, produce no bubble.
- Output handshake: the result is held stable until out_valid_o && out_ready_i.
  - In the same cycle a new result may load; otherwise out_valid_o returns to 0.
- Clamp: signed saturation of ACC_W to the OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - When OUT_W==ACC_W there is no clamping and out_sat_o is always 0.
- Accumulator arithmetic is two's-complement wrap at ACC_W. Sizing ACC_W for the maximum vector length is the integrator's responsibility; there is no internal overflow detection.
- Single-beat vector (first and last on the same beat): result = clamp(bias + sum).
- Gaps (in_valid_i low) between beats of a vector are allowed; accumulator state is retained.
- Inputs sampled only on acceptance; input values on non-accepted cycles are don't-care.

Decomposition:
- Package mac_pkg holds:
  - the lane packing helper function;
  - the function sat_clamp(acc, OUT_W) returning {sat, value};
  - a localparam for product width (2*N) and sum width (2*N+$clog2(LANES)).
- One sub-module: mac_adder_tree, a combinational signed reduction of LANES products, parameterised on LANES and input width, used in S2.

Test Plan:
All scenarios use N=8, LANES=4, ACC_W=24, OUT_W=16.
- Single beat: values {1,2,3,4}, weights {5,6,7,8}, bias 10, last=1 -> out_data_o=80, out_sat_o=0, out_valid_o exactly 2 cycles after acceptance.
- Multi-beat: 3 beats of values {1,1,1,1}, weights {2,2,2,2}, bias -5 (sampled on beat 1 only; bias_i=999 on beats 2-3), last on beat 3 -> out_data_o=19, sat 0.
- Saturation: values all -128, weights all -128, bias 0 -> out_data_o=32767, sat 1. Values all -128, weights all 127 -> out_data_o=-32768, sat 1.
- Backpressure: three back-to-back single-beat vectors (results 80, 19, 3) with out_ready_i low for 5 cycles after the first result appears:
  - result 80 is held stable and in_ready_o=0 during the stall;
  - all three results are emitted in order with none lost or duplicated.
- Reset mid-vector: accept 2 non-last beats, pulse rst_ni low for 1 cycle, then single beat values {1,0,0,0}, weights {3,0,0,0}, bias 0 -> out_data_o=3. out_valid_o is 0 during and immediately after reset.
- Gapped vector: 2-beat vector {1,2,3,4}·{1,1,1,1} twice with in_valid_i low for 3 cycles between beats, bias 0 -> out_data_o=20.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared constants and helpers for the mac_dot streaming
//                dot-product accumulator (lane packing, width derivation,
//                signed saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Default configuration of the block
    localparam int c_DEF_N     = 8;
    localparam int c_DEF_LANES = 4;
    localparam int c_DEF_ACC_W = 24;
    localparam int c_DEF_OUT_W = 16;

    // Product and lane-sum widths of the default configuration
    localparam int c_PROD_W = 2 * c_DEF_N;
    localparam int c_SUM_W  = 2 * c_DEF_N + $clog2(c_DEF_LANES);

    // Widest accumulator the clamp helper handles
    localparam int c_CLAMP_W = 64;

    typedef struct packed {
        logic                        sat;
        logic signed [c_CLAMP_W-1:0] value;
    } clamp_t;

    function automatic int prod_width(input int n);
        return 2 * n;
    endfunction

    function automatic int sum_width(input int n, input int lanes);
        return 2 * n + $clog2(lanes);
    endfunction

    // LSB position of lane 'lane' in a bus packed with 'width'-bit lanes
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Signed saturation of acc to the out_w-bit two's-complement range
    function automatic clamp_t sat_clamp(input logic signed [c_CLAMP_W-1:0] acc,
                                         input int out_w);
        logic signed [c_CLAMP_W-1:0] hi;
        logic signed [c_CLAMP_W-1:0] lo;
        clamp_t                      res;
        hi        = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo        = -hi - 64'sd1;
        res.sat   = 1'b0;
        res.value = acc;
        if (acc > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (acc < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_dot_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_dot_if
//  Description : Beat input / result output handshake bundle of mac_dot.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_dot_if
    import mac_pkg::*;
#(
    parameter int N     = c_DEF_N,
    parameter int LANES = c_DEF_LANES,
    parameter int ACC_W = c_DEF_ACC_W,
    parameter int OUT_W = c_DEF_OUT_W
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [LANES*N-1:0]      value_i;
    logic [LANES*N-1:0]      weight_i;
    logic signed [ACC_W-1:0] bias_i;
    logic                    last_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [OUT_W-1:0] out_data_o;
    logic                    out_sat_o;

    // Block side
    modport slave (
        input  in_valid_i, value_i, weight_i, bias_i, last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_sat_o
    );

    // Producer / consumer side
    modport master (
        output in_valid_i, value_i, weight_i, bias_i, last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_sat_o
    );
endinterface
`default_nettype wire

// File: rtl/mac_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : mac_adder_tree
//  Description : Combinational signed reduction of LANES packed operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int LANES = c_DEF_LANES,
    parameter int IN_W  = c_PROD_W,
    parameter int SUM_W = c_SUM_W
) (
    input  logic [LANES*IN_W-1:0] operands_i,
    output logic signed [SUM_W-1:0] sum_o
);

    // Sign-extend every operand to the sum width and add them all up
    always_comb begin
        sum_o = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_o = sum_o + SUM_W'($signed(operands_i[lane_lsb(k, IN_W) +: IN_W]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_dot.sv
`default_nettype none
// ============================================================================
//  Module      : mac_dot
//  Description : Streaming multi-lane signed dot-product accumulator.
//                S1 registers the lane products, S2 reduces them into a
//                bias-seeded accumulator and emits a saturated result on the
//                last beat of each vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_dot
    import mac_pkg::*;
#(
    parameter int N     = c_DEF_N,
    parameter int LANES = c_DEF_LANES,
    parameter int ACC_W = c_DEF_ACC_W,
    parameter int OUT_W = c_DEF_OUT_W
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mac_dot_if.slave  bus
);

    localparam int c_PW = prod_width(N);
    localparam int c_SW = sum_width(N, LANES);

    logic                    w_stall;
    logic                    w_accept;
    logic                    r_first;

    logic [LANES*c_PW-1:0]   w_prod;
    logic [LANES*c_PW-1:0]   r_s1_prod;
    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic                    r_s1_first;
    logic signed [ACC_W-1:0] r_s1_bias;

    logic signed [c_SW-1:0]  w_sum;
    logic signed [ACC_W-1:0] w_acc_base;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] r_acc;
    logic [OUT_W:0]          w_clamp;

    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;

    // A held, unconsumed result freezes the whole pipeline
    assign w_stall        = r_out_valid && !bus.out_ready_i;
    assign w_accept       = bus.in_valid_i && !w_stall;
    assign bus.in_ready_o = !w_stall;

    // Full-width signed product per lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [N-1:0] w_val;
        logic signed [N-1:0] w_wgt;
        assign w_val = bus.value_i[lane_lsb(k, N) +: N];
        assign w_wgt = bus.weight_i[lane_lsb(k, N) +: N];
        assign w_prod[lane_lsb(k, c_PW) +: c_PW] = c_PW'(w_val) * c_PW'(w_wgt);
    end

    // Tracks whether the next accepted beat opens a new vector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_first <= 1'b1;
        end else if (w_accept) begin
            r_first <= bus.last_i;
        end
    end

    // S1: capture products, vector flags and bias of the accepted beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_bias  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod  <= w_prod;
                r_s1_last  <= bus.last_i;
                r_s1_first <= r_first;
                r_s1_bias  <= bus.bias_i;
            end
        end
    end

    mac_adder_tree #(
        .LANES (LANES),
        .IN_W  (c_PW),
        .SUM_W (c_SW)
    ) u_adder_tree (
        .operands_i (r_s1_prod),
        .sum_o      (w_sum)
    );

    // A first beat restarts from its bias instead of the running total
    assign w_acc_base = r_s1_first ? r_s1_bias : r_acc;
    assign w_acc_next = w_acc_base + ACC_W'(w_sum);

    // The clamp helper returns {sat, value}; rotating the replicated result
    // right by the value width brings sat to bit 0 and the low value bits
    // directly above it, so only the bits actually needed are kept.
    assign w_clamp = (OUT_W + 1)'({2{sat_clamp(c_CLAMP_W'(w_acc_next), OUT_W)}} >> c_CLAMP_W);

    // S2: running accumulator, advanced by every valid beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (!w_stall && r_s1_valid) begin
            r_acc <= w_acc_next;
        end
    end

    // Result register: loads on a last beat, otherwise drains after handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid && r_s1_last) begin
                r_out_data <= w_clamp[OUT_W:1];
                r_out_sat  <= w_clamp[0];
            end
        end
    end

    assign bus.out_valid_o = r_out_valid;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_sat_o   = r_out_sat;

endmodule
`default_nettype wire
